// File: rtl/mac_tree_pkg.sv
`default_nettype none
// ============================================================================
// Package : mac_tree_pkg
// Purpose : Sizing helpers and saturation classifier shared by the MAC tree.
// Rev     : 1.0  initial release
// ============================================================================
package mac_tree_pkg;

  // Headroom the accumulator needs above a full-precision tree sum
  localparam int ACC_W_MARGIN = 4;
  localparam int SAT_IN_W     = 64;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_POS  = 2'd1,
    SAT_NEG  = 2'd2
  } sat_e;

  function automatic int tree_lvl(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int pad_lanes(input int n);
    return 1 << tree_lvl(n);
  endfunction

  function automatic int sum_w(input int dw, input int lvl);
    return 2 * dw + lvl;
  endfunction

  // Bit offset of tree level lvl inside the flattened all-levels bus
  function automatic int bus_off(input int n_pad, input int dw, input int lvl);
    int o;
    o = 0;
    for (int k = 0; k < lvl; k++) begin
      o += (n_pad >> k) * sum_w(dw, k);
    end
    return o;
  endfunction

  function automatic int acc_w_min(input int n, input int dw);
    return 2 * dw + tree_lvl(n) + ACC_W_MARGIN;
  endfunction

  function automatic sat_e sat_sel(input logic signed [SAT_IN_W-1:0] x, input int dw);
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) return SAT_POS;
    if (x < lo) return SAT_NEG;
    return SAT_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_tree_add_stage.sv
`default_nettype none
// ============================================================================
// Module  : mac_tree_add_stage
// Purpose : One registered adder-tree level; pairwise sign-extending adds with
//           valid and sideband delayed in lockstep.
// Rev     : 1.0  initial release
// ============================================================================
module mac_tree_add_stage #(
  parameter int IN_CNT = 2,
  parameter int IN_W   = 32,
  parameter int SB_W   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [SB_W-1:0]                in_sb,
  input  logic [IN_CNT*IN_W-1:0]         in_data,
  output logic                           out_valid,
  output logic [SB_W-1:0]                out_sb,
  output logic [(IN_CNT/2)*(IN_W+1)-1:0] out_data
);

  localparam int OUT_CNT = IN_CNT / 2;
  localparam int OUT_W   = IN_W + 1;

  logic [OUT_CNT*OUT_W-1:0] sum_d;
  logic [OUT_CNT*OUT_W-1:0] sum_q;
  logic [SB_W-1:0]          sb_q;
  logic                     valid_q;

  for (genvar p = 0; p < OUT_CNT; p++) begin : g_pair
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;
    assign a = in_data[2*p*IN_W +: IN_W];
    assign b = in_data[(2*p+1)*IN_W +: IN_W];
    assign sum_d[p*OUT_W +: OUT_W] = {a[IN_W-1], a} + {b[IN_W-1], b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sb_q    <= '0;
      sum_q   <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sb_q  <= in_sb;
        sum_q <= sum_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_sb    = sb_q;
  assign out_data  = sum_q;

endmodule
`default_nettype wire

// File: rtl/mac_tree_acc.sv
`default_nettype none
// ============================================================================
// Module  : mac_tree_acc
// Purpose : Pipelined N-lane signed dot product with chunk accumulation, bias,
//           ReLU, rescale and saturation. Macro SKIP_ADD_EN adds a residual.
// Rev     : 1.0  initial release
// ============================================================================
module mac_tree_acc
  import mac_tree_pkg::*;
#(
  parameter int N     = 16,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*DW-1:0]   act,
  input  logic [N*DW-1:0]   wgt,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [ACC_W-1:0]  bias,
  input  logic              relu_en,
  input  logic [DW-1:0]     skip_in,
  output logic [DW-1:0]     out,
  output logic              out_valid
);

  localparam int LVL      = tree_lvl(N);
  localparam int N_PAD    = pad_lanes(N);
  localparam int PW       = sum_w(DW, 0);
  localparam int TW       = sum_w(DW, LVL);
  localparam int BUS_W    = bus_off(N_PAD, DW, LVL + 1);
  localparam int TREE_OFF = bus_off(N_PAD, DW, LVL);
`ifdef SKIP_ADD_EN
  localparam int SB_W     = 3 + ACC_W + DW;
  localparam int RW       = ACC_W + 1;
`else
  localparam int SB_W     = 3 + ACC_W;
  localparam int RW       = ACC_W;
`endif

  if (ACC_W < acc_w_min(N, DW) || ACC_W > SAT_IN_W - 2) begin : g_bad_acc_w
    $error("mac_tree_acc: ACC_W outside supported range");
  end

  // Sideband layout: [0] last, [1] first, [2] relu, [3 +: ACC_W] bias, then skip
  logic [SB_W-1:0] w_sb_in;
  logic            first_q;
`ifdef SKIP_ADD_EN
  assign w_sb_in = {skip_in, bias, relu_en, first_q, in_last};
`else
  assign w_sb_in = {bias, relu_en, first_q, in_last};
  logic w_unused_skip;
  assign w_unused_skip = ^skip_in;
`endif

  // Stage M: lane products, zero-padded to a power of two
  logic [N_PAD*PW-1:0] w_prod;
  for (genvar i = 0; i < N_PAD; i++) begin : g_lane
    if (i < N) begin : g_mul
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] w;
      assign a = act[i*DW +: DW];
      assign w = wgt[i*DW +: DW];
      assign w_prod[i*PW +: PW] = a * w;
    end else begin : g_pad
      assign w_prod[i*PW +: PW] = '0;
    end
  end

  logic [N_PAD*PW-1:0] prod_q;
  logic [SB_W-1:0]     m_sb_q;
  logic                m_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q   <= 1'b1;
      m_valid_q <= 1'b0;
      m_sb_q    <= '0;
      prod_q    <= '0;
    end else begin
      m_valid_q <= in_valid;
      if (in_valid) begin
        first_q <= in_last;
        m_sb_q  <= w_sb_in;
        prod_q  <= w_prod;
      end
    end
  end

  // Stages T1..TLVL share one flattened bus, level l at bus_off(l)
  logic [BUS_W-1:0]        w_tree;
  logic [LVL:0]            w_tvld;
  logic [(LVL+1)*SB_W-1:0] w_tsb;

  assign w_tree[0 +: N_PAD*PW] = prod_q;
  assign w_tvld[0]             = m_valid_q;
  assign w_tsb[0 +: SB_W]      = m_sb_q;

  for (genvar l = 1; l <= LVL; l++) begin : g_lvl
    localparam int IN_CNT  = N_PAD >> (l - 1);
    localparam int IN_W    = sum_w(DW, l - 1);
    localparam int IN_OFF  = bus_off(N_PAD, DW, l - 1);
    localparam int OUT_OFF = bus_off(N_PAD, DW, l);

    mac_tree_add_stage #(
      .IN_CNT (IN_CNT),
      .IN_W   (IN_W),
      .SB_W   (SB_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_tvld[l-1]),
      .in_sb     (w_tsb[(l-1)*SB_W +: SB_W]),
      .in_data   (w_tree[IN_OFF +: IN_CNT*IN_W]),
      .out_valid (w_tvld[l]),
      .out_sb    (w_tsb[l*SB_W +: SB_W]),
      .out_data  (w_tree[OUT_OFF +: (IN_CNT/2)*(IN_W+1)])
    );
  end

  // Stage A: accumulator
  logic [TW-1:0]           w_tsum;
  logic [ACC_W-1:0]        w_tsum_ext;
  logic [SB_W-1:0]         w_a_sb;
  logic                    w_a_valid;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic                    a_emit_q;
  logic                    a_relu_q;

  assign w_tsum     = w_tree[TREE_OFF +: TW];
  assign w_tsum_ext = {{(ACC_W-TW){w_tsum[TW-1]}}, w_tsum};
  assign w_a_sb     = w_tsb[LVL*SB_W +: SB_W];
  assign w_a_valid  = w_tvld[LVL];

  always_comb begin
    acc_d = acc_q;
    if (w_a_valid) begin
      acc_d = (w_a_sb[1] ? w_a_sb[3 +: ACC_W] : acc_q) + w_tsum_ext;
    end
  end

`ifdef SKIP_ADD_EN
  logic [DW-1:0] a_skip_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_skip_q <= '0;
    end else if (w_a_valid && w_a_sb[0]) begin
      a_skip_q <= w_a_sb[3+ACC_W +: DW];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      a_emit_q <= 1'b0;
      a_relu_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      a_emit_q <= w_a_valid & w_a_sb[0];
      if (w_a_valid && w_a_sb[0]) begin
        a_relu_q <= w_a_sb[2];
      end
    end
  end

  // Stage O: rescale, ReLU, optional residual, saturate
  logic signed [ACC_W-1:0] w_shift;
  logic signed [ACC_W-1:0] w_relu;
  logic [RW-1:0]           w_res;
  sat_e                    w_sel;
  logic [DW-1:0]           out_q;
  logic [DW-1:0]           out_d;
  logic                    out_valid_q;

  assign w_shift = acc_q >>> FRAC;
  assign w_relu  = (a_relu_q && w_shift[ACC_W-1]) ? '0 : w_shift;
`ifdef SKIP_ADD_EN
  assign w_res   = {w_relu[ACC_W-1], w_relu} + {{(RW-DW){a_skip_q[DW-1]}}, a_skip_q};
`else
  assign w_res   = w_relu;
`endif
  assign w_sel   = sat_sel({{(SAT_IN_W-RW){w_res[RW-1]}}, w_res}, DW);

  always_comb begin
    out_d = out_q;
    if (a_emit_q) begin
      case (w_sel)
        SAT_POS: out_d = {1'b0, {(DW-1){1'b1}}};
        SAT_NEG: out_d = {1'b1, {(DW-1){1'b0}}};
        default: out_d = w_res[DW-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= a_emit_q;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_tree_acc.sv
`default_nettype none
// ============================================================================
// Module  : tb_mac_tree_acc
// Purpose : Self-checking bench for mac_tree_acc with a dot-product reference
//           model, directed corner cases and randomized chunk streams.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mac_tree_acc;

  localparam int N     = 16;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int ACC_W = 40;
  localparam int L     = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N*DW-1:0]   act = '0;
  logic [N*DW-1:0]   wgt = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic [ACC_W-1:0]  bias = '0;
  logic              relu_en = 1'b0;
  logic [DW-1:0]     skip_in = '0;
  logic [DW-1:0]     out;
  logic              out_valid;

  always #5 clk = ~clk;

  mac_tree_acc #(.N(N), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .act       (act),
    .wgt       (wgt),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .bias      (bias),
    .relu_en   (relu_en),
    .skip_in   (skip_in),
    .out       (out),
    .out_valid (out_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    int          edge_no;
    logic [15:0] val;
  } exp_t;
  exp_t expq[$];

  logic signed [15:0] la [N];
  logic signed [15:0] lw [N];
  bit     m_first = 1'b1;
  longint m_acc   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint x);
    longint r;
    r = x & ((longint'(1) <<< ACC_W) - 1);
    if (r[ACC_W-1]) r = r - (longint'(1) <<< ACC_W);
    return r;
  endfunction

  function automatic logic [15:0] model_out(input longint acc, input bit relu, input logic signed [15:0] sk);
    longint r;
    r = acc >>> FRAC;
    if (relu && r < 0) r = 0;
`ifdef SKIP_ADD_EN
    r = r + longint'(sk);
`else
    if (sk != sk) r = 0;
`endif
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic drive(input bit v, input bit last, input longint b, input bit relu, input logic [15:0] sk);
    longint s;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      act[i*DW +: DW] = la[i];
      wgt[i*DW +: DW] = lw[i];
    end
    in_valid = v;
    in_last  = last;
    bias     = b[ACC_W-1:0];
    relu_en  = relu;
    skip_in  = sk;
    if (v) begin
      s = 0;
      for (int i = 0; i < N; i++) s += longint'(la[i]) * longint'(lw[i]);
      m_acc = wrap_acc((m_first ? b : m_acc) + s);
      if (last) begin
        expq.push_back('{edges + L, model_out(m_acc, relu, sk)});
        m_first = 1'b1;
      end else begin
        m_first = 1'b0;
      end
    end
  endtask

  task automatic wait_res(input int e0, output logic [15:0] v, output int lat, output int pulses);
    pulses = 0;
    lat    = -1;
    v      = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (out_valid === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = edges - e0;
          v   = out;
        end
      end
    end
  endtask

  task automatic set_lanes(input logic [15:0] a, input logic [15:0] w);
    for (int i = 0; i < N; i++) begin
      la[i] = a;
      lw[i] = w;
    end
  endtask

  task automatic check_result(input string name, input int e0, input logic [15:0] exp);
    logic [15:0] v;
    int lat, p;
    chk({name, "_model"}, expq[expq.size()-1].val, exp);
    wait_res(e0, v, lat, p);
    chk({name, "_out"}, v, exp);
    chk({name, "_latency"}, lat, L);
    chk({name, "_pulses"}, p, 1);
  endtask

  task automatic one_shot(input string name, input logic [15:0] a, input logic [15:0] w,
                          input bit relu, input logic [15:0] sk, input logic [15:0] exp);
    set_lanes(a, w);
    drive(1'b1, 1'b1, 0, relu, sk);
    check_result(name, edges, exp);
  endtask

  // Every-cycle comparison against the model's expected output stream
  always @(negedge clk) begin
    if (expq.size() > 0 && expq[0].edge_no == edges) begin
      chk("stream_valid", out_valid, 1);
      chk("stream_out", out, expq[0].val);
      void'(expq.pop_front());
    end else begin
      chk("stream_idle", out_valid, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int lat, p, e0;
    set_lanes(16'h0000, 16'h0000);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out", out, 0);
    chk("reset_valid", out_valid, 0);
    rst = 1'b0;

    one_shot("unit_sum", 16'h0100, 16'h0100, 1'b0, 16'h0000, 16'h1000);

    set_lanes(16'h0100, 16'h0100);
    drive(1'b1, 1'b0, 64'h10000, 1'b0, 16'h0000);
    drive(1'b1, 1'b1, 64'h12345, 1'b0, 16'h0000);
    check_result("two_chunk_bias", edges, 16'h2100);

    one_shot("relu_on", 16'h0100, 16'hFF00, 1'b1, 16'h0000, 16'h0000);
    one_shot("relu_off", 16'h0100, 16'hFF00, 1'b0, 16'h0000, 16'hF000);
    one_shot("sat_pos", 16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 16'h7FFF);
    one_shot("sat_neg", 16'h7FFF, 16'h8001, 1'b0, 16'h0000, 16'h8000);
`ifdef SKIP_ADD_EN
    one_shot("skip_add", 16'h0100, 16'h0100, 1'b0, 16'h0100, 16'h1100);
`else
    one_shot("skip_add", 16'h0100, 16'h0100, 1'b0, 16'h0100, 16'h1000);
`endif

    // Reset in the middle of a three-chunk product
    set_lanes(16'h0100, 16'h0100);
    drive(1'b1, 1'b0, 64'h30000, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 0, 1'b0, 16'h0000);
    @(posedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    expq.delete();
    m_first  = 1'b1;
    m_acc    = 0;
    #1;
    chk("midreset_out", out, 0);
    chk("midreset_valid", out_valid, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    set_lanes(16'h0200, 16'h0100);
    drive(1'b1, 1'b1, 0, 1'b0, 16'h0000);
    e0 = edges;
    chk("fresh_model", expq[expq.size()-1].val, 16'h2000);
    wait_res(e0, v, lat, p);
    chk("fresh_out", v, 16'h2000);
    chk("fresh_pulses", p, 1);

    // Randomized chunk streams with gaps and stray in_last
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 0, 1'b0, 16'h0000);
      end else begin
        for (int i = 0; i < N; i++) begin
          la[i] = 16'($urandom);
          lw[i] = 16'($urandom);
        end
        drive(1'b1, $urandom_range(0, 3) == 0, longint'(int'($urandom)),
              1'($urandom_range(0, 1)), 16'($urandom));
      end
    end
    repeat (20) drive(1'b0, 1'b0, 0, 1'b0, 16'h0000);
    chk("drain_pending", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_tree_acc.md
# mac_tree_acc

Parametrised pipelined dot-product engine for the SqueezeNext convolution layers. It multiplies N signed fixed-point activation/weight pairs per cycle and reduces them through a registered binary adder tree. Results are accumulated across a stream of chunks, with bias seeded on the first chunk. On the last chunk it emits one ReLU'd, rescaled, saturated output with an optional residual (skip) add. It replaces the fixed 16-input per-layer trees with a single block instantiated by every layer, and adds valid/last framing the older trees lack.

## Interface
- N, 16, number of multiplier lanes (≥2; non-power-of-2 padded with zero lanes)
- DW, 16, activation/weight/output width, signed two's complement
- FRAC, 8, fractional bits of DW operands; products carry 2*FRAC
- ACC_W, 40, accumulator width (≥ 2*DW + clog2(N) + 4)

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- act  in  N*DW  activations, lane i at [DW*(i+1)-1:DW*i]
- wgt  in  N*DW  weights, same packing
- in_valid  in  1  chunk present this cycle
- in_last  in  1  chunk is final of current dot product (qualified by in_valid)
- bias  in  ACC_W  signed, scale 2*FRAC; sampled with first chunk of each dot product
- relu_en  in  1  1 = clamp negative to 0; sampled with the last chunk
- skip_in  in  DW  residual operand, scale FRAC; sampled with the last chunk
- out  out  DW  result, signed
- out_valid  out  1  one-cycle pulse per dot product

## Operation
- Stage M: N signed DW×DW products (2*DW bits), registered with in_valid/in_last/first/bias/relu_en/skip_in sideband.
- Stages T1..TLVL, LVL = clog2(N): pairwise sign-extending adds, +1 bit per level, each level registered; sideband delayed in lockstep.
- Stage A: accumulator register. Internal flag first = 1 after reset and after each last chunk.
  - valid & first: acc ← bias + tree_sum.
  - valid & !first: acc ← acc + tree_sum.
  - No valid: acc holds.
  - Wraps two's-complement at ACC_W; sizing via the ACC_W rule is the caller's responsibility.
- Stage O, when the last chunk leaves A:
  - r = acc >>> FRAC (arithmetic).
  - If relu_en and r < 0, r = 0.
  - r = r + sign-extended skip_in (when SKIP_ADD_EN).
  - Saturate to [−2^(DW−1), 2^(DW−1)−1].
  - Register into out; pulse out_valid.
- Single-chunk dot product (in_valid & in_last on a first chunk): the bias is seeded and the result emitted from that chunk alone.
- Back-to-back: a new first chunk may arrive the cycle after a last chunk; no bubbles are required. Gaps between chunks are allowed; the partial sum holds.
- No backpressure: the consumer must accept every out_valid pulse.
- in_last without in_valid is ignored.

## Timing
- Latency L = LVL + 3 edges from the sampling of the last chunk to out_valid high (N=16: L=7).
- Throughput: one chunk per cycle; one result per last chunk.
- Reset values: out = 0, out_valid = 0, acc = 0, all pipeline valids = 0, first = 1.
- Reset mid-operation discards in-flight chunks and any partial sum. No out_valid is produced for them.

## Configuration
- SKIP_ADD_EN defined: skip_in is pipelined and added after ReLU, before saturation.
- SKIP_ADD_EN undefined: skip_in is ignored, no skip pipeline registers are built, and out = sat(relu(acc >>> FRAC)).

## Structure
- Package mac_tree_pkg holds:
  - the clog2-based LVL and padded-width constants,
  - the per-level sum width function,
  - the saturate-to-DW function,
  - the ACC_W minimum check constant.
- Sub-module mac_tree_add_stage: one registered tree level, parametrised by input count and input width. It carries valid and the sideband, and is instantiated LVL times via generate.

## Test plan
Defaults used throughout: N=16, DW=16, FRAC=8.
- Reset release; all lanes act=wgt=0x0100, bias=0, one chunk with in_last -> out=0x1000, out_valid exactly 7 cycles later, single pulse.
- Two chunks of the same data, bias=0x10000 (1.0) on the first -> out=0x2100; the second chunk's bias value is ignored.
- act=0x0100, wgt=0xFF00 (−1.0), one chunk: relu_en=1 -> out=0x0000; relu_en=0 -> out=0xF000.
- act=wgt=0x7FFF all lanes, one chunk -> out saturates to 0x7FFF. Same magnitude negative with relu_en=0 -> 0x8000.
- SKIP_ADD_EN built, skip_in=0x0100, sum 16.0 -> out=0x1100. Without the macro, same stimulus -> 0x1000.
- Assert rst between the first and last chunk of a 3-chunk product, then send a fresh single chunk -> only one out_valid, carrying the fresh result.
